// File: rtl/sblock_pkg.sv
// rtl/sblock_pkg.sv - shared types and sizing helpers for the sblock_cfg switch block
//   sblock_state_e : loader FSM states (IDLE, LOAD, FULL)
//   sblock_nbits   : configuration vector width, 2*W*W (V enables low, H enables high)
//   sblock_nbeats  : beats needed to carry the vector, ceil(nbits/cw)
//   sblock_bw      : beat index width, max(1, clog2(nbeats))
package sblock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } sblock_state_e;

  localparam int SBLOCK_W_DEFAULT  = 3;
  localparam int SBLOCK_CW_DEFAULT = 8;

  function automatic int sblock_nbits(input int w);
    return 2 * w * w;
  endfunction

  function automatic int sblock_nbeats(input int w, input int cw);
    return (sblock_nbits(w) + cw - 1) / cw;
  endfunction

  function automatic int sblock_bw(input int w, input int cw);
    int n;
    int b;
    n = sblock_nbeats(w, cw);
    b = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << b) < n) b = b + 1;
    end
    return b;
  endfunction

endpackage

// File: rtl/sblock_cfg_loader.sv
// rtl/sblock_cfg_loader.sv - beat loader: FSM, beat counter, shadow and active configuration registers
//   clk, rst_n            : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready   : beat handshake, cfg_data carries one CW-bit beat
//   cfg_commit/cfg_abort  : single-cycle control pulses
//   cfg_done/cfg_err      : registered one-cycle status pulses
//   rb_req/rb_idx         : readback request (only with SBLOCK_CFG_READBACK_EN)
//   rb_valid/rb_data      : readback response (only with SBLOCK_CFG_READBACK_EN)
//   active                : committed configuration vector driving the gating array
module sblock_cfg_loader
  import sblock_pkg::*;
#(
  parameter int W      = SBLOCK_W_DEFAULT,
  parameter int CW     = SBLOCK_CW_DEFAULT,
  parameter int NBITS  = sblock_nbits(W),
  parameter int NBEATS = sblock_nbeats(W, CW),
  parameter int BW     = sblock_bw(W, CW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_data,
  input  logic             cfg_commit,
  input  logic             cfg_abort,
  output logic             cfg_done,
  output logic             cfg_err,
`ifdef SBLOCK_CFG_READBACK_EN
  input  logic             rb_req,
  input  logic [BW-1:0]    rb_idx,
  output logic             rb_valid,
  output logic [CW-1:0]    rb_data,
`endif
  output logic [NBITS-1:0] active
);

  sblock_state_e    state;
  sblock_state_e    state_nxt;
  logic [BW-1:0]    cnt;
  logic [BW-1:0]    cnt_nxt;
  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] shadow_nxt;
  logic [NBITS-1:0] active_q;
  logic             beat_acc;
  logic             commit_ok;
  logic             commit_bad;

  // Abort suppresses every other action in its cycle, including status pulses.
  assign beat_acc   = cfg_valid & cfg_ready & ~cfg_abort;
  assign commit_ok  = cfg_commit & ~cfg_abort & (state == FULL);
  assign commit_bad = cfg_commit & ~cfg_abort & (state != FULL);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. A commit outside FULL only raises cfg_err; it never moves
  // the FSM, so a beat arriving alongside it is still taken.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (cfg_abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat_acc) begin
            if (NBEATS == 1) begin
              state_nxt = FULL;
              cnt_nxt   = '0;
            end else begin
              state_nxt = LOAD;
              cnt_nxt   = BW'(1);
            end
          end
        end
        LOAD: begin
          if (beat_acc) begin
            if (cnt == BW'(NBEATS - 1)) begin
              state_nxt = FULL;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + BW'(1);
            end
          end
        end
        FULL: begin
          if (cfg_commit) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    cfg_ready = (state != FULL);
  end

  // cnt is held at 0 in IDLE, so it is the slot index in both IDLE and LOAD.
  // Beat bits that land at or above NBITS have no shadow bit and fall away.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NBITS; i++) begin
      if (beat_acc && ((i / CW) == int'(cnt))) shadow_nxt[i] = cfg_data[i % CW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      active_q <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      shadow   <= shadow_nxt;
      if (commit_ok) active_q <= shadow;
      cfg_done <= commit_ok;
      cfg_err  <= commit_bad;
    end
  end

  assign active = active_q;

`ifdef SBLOCK_CFG_READBACK_EN
  // Reads active_q before any same-edge commit lands, giving the pre-commit view.
  // Indices past the last beat match no bit and return zero.
  logic [CW-1:0] rb_data_nxt;

  always_comb begin
    rb_data_nxt = '0;
    for (int i = 0; i < NBITS; i++) begin
      if ((i / CW) == int'(rb_idx)) rb_data_nxt[i % CW] = active_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else begin
      rb_valid <= rb_req;
      if (rb_req) rb_data <= rb_data_nxt;
    end
  end
`endif

endmodule

// File: rtl/sblock_cfg.sv
// rtl/sblock_cfg.sv - W x W switch block with streamed, atomically committed configuration
//   optional feature macro: SBLOCK_CFG_READBACK_EN (adds rb_req/rb_idx/rb_valid/rb_data)
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_*                : configuration beat stream and commit/abort control
//   left_i -> right_o    : horizontal tracks, bit r = row r (row 0 at the bottom)
//   up_i   -> down_o     : vertical tracks, bit c = column c (column 0 at the right)
module sblock_cfg
  import sblock_pkg::*;
#(
  parameter int W      = SBLOCK_W_DEFAULT,
  parameter int CW     = SBLOCK_CW_DEFAULT,
  localparam int NBITS  = sblock_nbits(W),
  localparam int NBEATS = sblock_nbeats(W, CW),
  localparam int BW     = sblock_bw(W, CW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_data,
  input  logic          cfg_commit,
  input  logic          cfg_abort,
  output logic          cfg_done,
  output logic          cfg_err,
`ifdef SBLOCK_CFG_READBACK_EN
  input  logic          rb_req,
  input  logic [BW-1:0] rb_idx,
  output logic          rb_valid,
  output logic [CW-1:0] rb_data,
`endif
  input  logic [W-1:0]  left_i,
  input  logic [W-1:0]  up_i,
  output logic [W-1:0]  right_o,
  output logic [W-1:0]  down_o
);

  logic [NBITS-1:0] active;

  sblock_cfg_loader #(
    .W      (W),
    .CW     (CW),
    .NBITS  (NBITS),
    .NBEATS (NBEATS),
    .BW     (BW)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_abort  (cfg_abort),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
`ifdef SBLOCK_CFG_READBACK_EN
    .rb_req     (rb_req),
    .rb_idx     (rb_idx),
    .rb_valid   (rb_valid),
    .rb_data    (rb_data),
`endif
    .active     (active)
  );

  // A track crosses every dot on its row/column; each dot's enable gates it in
  // series, so the track reaches the far side only if all its dots are enabled.
  for (genvar r = 0; r < W; r++) begin : g_row
    logic [W-1:0] h_en;
    for (genvar c = 0; c < W; c++) begin : g_dot
      assign h_en[c] = active[W*W + r*W + c];
    end
    assign right_o[r] = left_i[r] & (&h_en);
  end

  for (genvar c = 0; c < W; c++) begin : g_col
    logic [W-1:0] v_en;
    for (genvar r = 0; r < W; r++) begin : g_dot
      assign v_en[r] = active[r*W + c];
    end
    assign down_o[c] = up_i[c] & (&v_en);
  end

endmodule

// File: tb/tb_sblock_cfg.sv
// tb/tb_sblock_cfg.sv - self-checking bench for sblock_cfg (W=3, CW=8)
module tb_sblock_cfg;

  localparam int W      = 3;
  localparam int CW     = 8;
  localparam int NBITS  = 18;
  localparam int NBEATS = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_data = '0;
  logic          cfg_commit = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          cfg_done;
  logic          cfg_err;
  logic [W-1:0]  left_i = '0;
  logic [W-1:0]  up_i = '0;
  logic [W-1:0]  right_o;
  logic [W-1:0]  down_o;
`ifdef SBLOCK_CFG_READBACK_EN
  logic          rb_req = 1'b0;
  logic [1:0]    rb_idx = '0;
  logic          rb_valid;
  logic [CW-1:0] rb_data;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: committed vector plus the list of beats received since
  // the last commit/abort/reset.
  logic [NBITS-1:0] m_active = '0;
  logic [7:0]       m_q[$];

  always #5 clk = ~clk;

  sblock_cfg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_abort  (cfg_abort),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
`ifdef SBLOCK_CFG_READBACK_EN
    .rb_req     (rb_req),
    .rb_idx     (rb_idx),
    .rb_valid   (rb_valid),
    .rb_data    (rb_data),
`endif
    .left_i     (left_i),
    .up_i       (up_i),
    .right_o    (right_o),
    .down_o     (down_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NBITS-1:0] pack_q();
    logic [23:0] v;
    v = '0;
    foreach (m_q[k]) v[k*8 +: 8] = m_q[k];
    return v[NBITS-1:0];
  endfunction

  // A row passes only if every H enable along it is set; likewise columns with V.
  function automatic logic [2:0] exp_right(input logic [NBITS-1:0] a, input logic [2:0] l);
    logic [2:0] res;
    for (int r = 0; r < W; r++) begin
      res[r] = l[r];
      for (int c = 0; c < W; c++) if (!a[W*W + r*W + c]) res[r] = 1'b0;
    end
    return res;
  endfunction

  function automatic logic [2:0] exp_down(input logic [NBITS-1:0] a, input logic [2:0] u);
    logic [2:0] res;
    for (int c = 0; c < W; c++) begin
      res[c] = u[c];
      for (int r = 0; r < W; r++) if (!a[r*W + c]) res[c] = 1'b0;
    end
    return res;
  endfunction

  function automatic logic [7:0] rb_exp(input logic [NBITS-1:0] a, input int idx);
    logic [23:0] p;
    p = {6'b0, a};
    if (idx >= NBEATS) return 8'h00;
    return p[idx*8 +: 8];
  endfunction

  // One clock cycle of stimulus with model update and status checks.
  task automatic drive(input string tag, input logic v, input logic [7:0] d,
                       input logic cm, input logic ab);
    logic rdy;
    logic e_done;
    logic e_err;
    rdy = (m_q.size() < NBEATS);
    check({tag, ".ready"}, {31'b0, cfg_ready}, {31'b0, rdy});
    e_done = 1'b0;
    e_err  = 1'b0;
    if (ab) begin
      m_q.delete();
    end else begin
      if (cm) begin
        if (m_q.size() == NBEATS) begin
          m_active = pack_q();
          m_q.delete();
          e_done = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end
      if (v && rdy) m_q.push_back(d);
    end
    cfg_valid = v; cfg_data = d; cfg_commit = cm; cfg_abort = ab;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_abort = 1'b0;
    check({tag, ".done"}, {31'b0, cfg_done}, {31'b0, e_done});
    check({tag, ".err"}, {31'b0, cfg_err}, {31'b0, e_err});
  endtask

  task automatic route_check(input string tag, input logic [2:0] l, input logic [2:0] u);
    left_i = l;
    up_i   = u;
    #1;
    check({tag, ".right"}, {29'b0, right_o}, {29'b0, exp_right(m_active, l)});
    check({tag, ".down"}, {29'b0, down_o}, {29'b0, exp_down(m_active, u)});
  endtask

  task automatic load_vec(input string tag, input logic [NBITS-1:0] vec, input logic [5:0] pad);
    logic [23:0] p;
    logic [7:0]  b;
    p = {pad, vec};
    for (int k = 0; k < NBEATS; k++) begin
      b = p[k*8 +: 8];
      drive(tag, 1'b1, b, 1'b0, 1'b0);
    end
  endtask

`ifdef SBLOCK_CFG_READBACK_EN
  task automatic rb_check(input string tag, input logic [1:0] idx);
    logic [7:0] e;
    e = rb_exp(m_active, int'(idx));
    rb_req = 1'b1;
    rb_idx = idx;
    tick();
    rb_req = 1'b0;
    check({tag, ".rbv"}, {31'b0, rb_valid}, 32'd1);
    check({tag, ".rbd"}, {24'b0, rb_data}, {24'b0, e});
  endtask
`endif

  initial begin
    logic [NBITS-1:0] vec;
    logic [2:0]       l;
    logic [2:0]       u;

    // Reset with all track inputs high: every path must be blocked.
    rst_n  = 1'b0;
    left_i = 3'b111;
    up_i   = 3'b111;
    #2;
    check("rst.right", {29'b0, right_o}, 32'd0);
    check("rst.down", {29'b0, down_o}, 32'd0);
    check("rst.ready", {31'b0, cfg_ready}, 32'd1);
    check("rst.done", {31'b0, cfg_done}, 32'd0);
    check("rst.err", {31'b0, cfg_err}, 32'd0);
`ifdef SBLOCK_CFG_READBACK_EN
    check("rst.rbv", {31'b0, rb_valid}, 32'd0);
    check("rst.rbd", {24'b0, rb_data}, 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;

    // Full load, all enables set.
    drive("full.b0", 1'b1, 8'hFF, 1'b0, 1'b0);
    drive("full.b1", 1'b1, 8'hFF, 1'b0, 1'b0);
    drive("full.b2", 1'b1, 8'h03, 1'b0, 1'b0);
    check("full.stall", {31'b0, cfg_ready}, 32'd0);
    drive("full.cm", 1'b0, 8'h00, 1'b1, 1'b0);
    check("full.done", {31'b0, cfg_done}, 32'd1);
    left_i = 3'b101; up_i = 3'b011; #1;
    check("full.right", {29'b0, right_o}, 32'h5);
    check("full.down", {29'b0, down_o}, 32'h3);
    drive("full.idle", 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef SBLOCK_CFG_READBACK_EN
    rb_check("rb2", 2'd2);
    check("rb2.const", {24'b0, rb_data}, 32'h03);
    rb_check("rb3", 2'd3);
    rb_check("rb0", 2'd0);
`endif

    // Partial route: clear H[4] (row 1, column 1).
    vec = 18'h3FFFF;
    vec[W*W + 4] = 1'b0;
    load_vec("part", vec, 6'h00);
    drive("part.cm", 1'b0, 8'h00, 1'b1, 1'b0);
    left_i = 3'b111; #1;
    check("part.right", {29'b0, right_o}, 32'h5);
    route_check("part", 3'b111, 3'b111);

    // Early commit after two beats, then finish the load.
    drive("early.b0", 1'b1, 8'h00, 1'b0, 1'b0);
    drive("early.b1", 1'b1, 8'h00, 1'b0, 1'b0);
    drive("early.cm", 1'b0, 8'h00, 1'b1, 1'b0);
    check("early.err", {31'b0, cfg_err}, 32'd1);
    route_check("early.hold", 3'b111, 3'b111);
    drive("early.b2", 1'b1, 8'h00, 1'b0, 1'b0);
    drive("early.cm2", 1'b0, 8'h00, 1'b1, 1'b0);
    left_i = 3'b111; #1;
    check("early.right0", {29'b0, right_o}, 32'd0);

    // Reload all ones, then abort a second load with a simultaneous commit.
    load_vec("ab.pre", 18'h3FFFF, 6'h2A);
    drive("ab.precm", 1'b0, 8'h00, 1'b1, 1'b0);
    drive("ab.b0", 1'b1, 8'h00, 1'b0, 1'b0);
    drive("ab.b1", 1'b1, 8'h00, 1'b0, 1'b0);
    drive("ab.abcm", 1'b0, 8'h00, 1'b1, 1'b1);
    route_check("ab.hold", 3'b111, 3'b111);
    load_vec("ab.re", 18'h2A5C3, 6'h15);
    drive("ab.recm", 1'b0, 8'h00, 1'b1, 1'b0);
    route_check("ab.new", 3'b111, 3'b111);

    // Final beat and commit in the same LOAD cycle.
    drive("cb.b0", 1'b1, 8'hFF, 1'b0, 1'b0);
    drive("cb.b1", 1'b1, 8'hFF, 1'b0, 1'b0);
    drive("cb.b2cm", 1'b1, 8'hFF, 1'b1, 1'b0);
    drive("cb.cm", 1'b0, 8'h00, 1'b1, 1'b0);
    route_check("cb", 3'b110, 3'b101);

`ifdef SBLOCK_CFG_READBACK_EN
    // Readback in the commit cycle must see the pre-commit value.
    load_vec("rbc", 18'h00F0F, 6'h3F);
    rb_req = 1'b1; rb_idx = 2'd0;
    vec = m_active;
    drive("rbc.cm", 1'b0, 8'h00, 1'b1, 1'b0);
    rb_req = 1'b0;
    check("rbc.rbd", {24'b0, rb_data}, {24'b0, rb_exp(vec, 0)});
    rb_check("rbc.post", 2'd0);
`endif

    // Randomised cycles against the model.
    for (int n = 0; n < 300; n++) begin
      logic v;
      logic cm;
      logic ab;
      logic [7:0] d;
`ifdef SBLOCK_CFG_READBACK_EN
      logic       rq;
      logic [1:0] ri;
      logic [7:0] re;
      rq = 1'($urandom_range(0, 1));
      ri = 2'($urandom_range(0, 3));
      re = rb_exp(m_active, int'(ri));
      rb_req = rq; rb_idx = ri;
`endif
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      cm = ($urandom_range(0, 4) == 0);
      ab = ($urandom_range(0, 11) == 0);
      drive("rnd", v, d, cm, ab);
`ifdef SBLOCK_CFG_READBACK_EN
      rb_req = 1'b0;
      check("rnd.rbv", {31'b0, rb_valid}, {31'b0, rq});
      if (rq) check("rnd.rbd", {24'b0, rb_data}, {24'b0, re});
`endif
      l = 3'($urandom);
      u = 3'($urandom);
      route_check("rnd", l, u);
    end

    // Reset in the middle of a load clears everything.
    drive("mid.b0", 1'b1, 8'hFF, 1'b0, 1'b0);
    drive("mid.b1", 1'b1, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b0;
    m_active = '0;
    m_q.delete();
    #1;
    check("mid.ready", {31'b0, cfg_ready}, 32'd1);
    route_check("mid", 3'b111, 3'b111);
    tick();
    rst_n = 1'b1;
    load_vec("mid.re", 18'h3FFFF, 6'h00);
    drive("mid.cm", 1'b0, 8'h00, 1'b1, 1'b0);
    route_check("mid.after", 3'b111, 3'b111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
